// File: rtl/lfsr_checker.sv
// Receive-side checker for the 3-bit LFSR pattern generator: acquires lock, flags and counts mispredicted words.
// Optional zero-word detector enabled by defining LFSR_CHK_ZERO_DET_EN.
module lfsr_checker #(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk_i,
  input  logic             set_i,
  input  logic             in_valid_i,
  input  logic [2:0]       in_data_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic             zero_det_o
);

  // state | meaning
  // HUNT  | waiting for a nonzero seed word
  // SYNC  | seeded, counting consecutive correct predictions
  // LOCK  | locked; prediction flywheels from pred, misses raise err
  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_SYNC = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(LOSS_CNT + 1);

  function automatic logic [2:0] lfsr_next(input logic [2:0] s);
    return {s[1:0], s[2] ^ s[1]};
  endfunction

  state_t             state_q, state_d;
  logic [2:0]         pred_q, pred_d;
  logic [MATCH_W-1:0] match_cnt_q, match_cnt_d, match_inc;
  logic [MISS_W-1:0]  miss_cnt_q, miss_cnt_d, miss_inc;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               err_q, err_d;
  logic               word_match;
  logic               word_zero;

  assign word_match = (in_data_i == pred_q);
  assign word_zero  = (in_data_i == 3'b000);
  assign match_inc  = match_cnt_q + 1'b1;
  assign miss_inc   = miss_cnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (set_i) begin
      state_q     <= ST_HUNT;
      pred_q      <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      err_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_d       = 1'b0;
    if (in_valid_i) begin
      case (state_q)
        ST_HUNT: begin
          if (!word_zero) begin
            pred_d      = lfsr_next(in_data_i);
            match_cnt_d = '0;
            state_d     = ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (word_match) begin
            match_cnt_d = match_inc;
            pred_d      = lfsr_next(in_data_i);
            if (match_inc == MATCH_W'(LOCK_CNT)) begin
              state_d    = ST_LOCK;
              miss_cnt_d = '0;
            end
          end else if (!word_zero) begin
            pred_d      = lfsr_next(in_data_i);
            match_cnt_d = '0;
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_LOCK: begin
          // Flywheel: a corrupted word never disturbs the prediction.
          pred_d = lfsr_next(pred_q);
          if (word_match) begin
            miss_cnt_d = '0;
          end else begin
            err_d      = 1'b1;
            miss_cnt_d = miss_inc;
            if (err_cnt_q != {ERR_W{1'b1}}) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
            if (miss_inc == MISS_W'(LOSS_CNT)) begin
              state_d = ST_HUNT;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  assign locked_o  = (state_q == ST_LOCK);
  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;

`ifdef LFSR_CHK_ZERO_DET_EN
  logic zero_det_q;

  always_ff @(posedge clk_i) begin
    if (set_i) begin
      zero_det_q <= 1'b0;
    end else begin
      zero_det_q <= in_valid_i && word_zero;
    end
  end

  assign zero_det_o = zero_det_q;
`else
  assign zero_det_o = 1'b0;
`endif

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side companion to the 3-bit LFSR pattern generator: it samples the generator's 3-bit state word and predicts each next word from the same recurrence. It acquires lock to the sequence, flags and counts mismatching words, and drops lock after repeated misses. It sits at the far end of any link or datapath under test that the LFSR drives, and gives a self-checking pass/fail for that path.

## Interface
- LOCK_CNT, 3, consecutive correctly predicted words required to enter LOCK (≥1)
- LOSS_CNT, 2, consecutive mispredicted words in LOCK that force a return to HUNT (≥1)
- ERR_W, 8, width of the error counter

- clk  input  1  sole clock; all logic on rising edge
- set  input  1  synchronous, active-high reset; overrides all other inputs
- in_valid  input  1  in_data is sampled this cycle
- in_data  input  3  received LFSR state word
- locked  output  1  checker is in LOCK
- err  output  1  one-cycle pulse per mispredicted word while locked
- err_cnt  output  ERR_W  saturating count of err pulses since reset
- zero_det  output  1  one-cycle pulse on a valid all-zero word (only with macro, else tied 0)

## Operation
- Recurrence: next(s) = {s[1:0], s[2]^s[1]}. Period 7: 001→010→101→011→111→110→100→001. 000 is the lock-up word and is never legal.
- Registers: pred (3b), state, match_cnt, miss_cnt, err_cnt. All registers and outputs are 0 after set; state = HUNT.
- in_valid low: no register changes; err and zero_det low.
- HUNT: valid nonzero word → pred = next(in_data), match_cnt = 0, go SYNC. Valid 000 → stay HUNT.
- SYNC: valid word == pred → match_cnt+1; on reaching LOCK_CNT go LOCK, miss_cnt = 0; pred = next(in_data). Mismatch, nonzero → reseed (pred = next(in_data), match_cnt = 0), stay SYNC. Mismatch 000 → HUNT. No err in SYNC.
- LOCK: match → miss_cnt = 0. Mismatch → err pulse, err_cnt+1 (saturating at 2^ERR_W−1), miss_cnt+1; on reaching LOSS_CNT go HUNT. Flywheel: in LOCK pred always advances from pred (pred = next(pred)), never from in_data, so one corrupted word costs exactly one error.
- err_cnt is not cleared by loss of lock; only by set.
- set in the same cycle as in_valid: set wins, the word is discarded.

## Timing
- All outputs registered; one-cycle latency from the sampling edge.
- locked rises on the edge that samples the LOCK_CNT-th matching word after the seed word; it is visible in the following cycle. With defaults, the 4th consecutive valid word of a clean sequence (seed + 3 matches) asserts locked.
- locked falls on the edge that samples the LOSS_CNT-th consecutive miss; that miss still produces err and increments err_cnt.
- err and zero_det are high for exactly one cycle per offending valid word; back-to-back offending words produce back-to-back pulses.
- Gaps in in_valid of any length are transparent: the prediction resumes at the next valid word.

## Configuration
- LFSR_CHK_ZERO_DET_EN defined: a valid 000 word pulses zero_det in any state. In LOCK it also counts as a miss (err, err_cnt, miss_cnt). In HUNT/SYNC it behaves as above.
- Not defined: zero_det is tied to 0 and has no logic. 000 is still handled as a mismatch per the state rules.

## Test plan
- set 2 cycles, then valid 001,010,101,011 on consecutive cycles → locked=1 the cycle after 011, err_cnt=0, err never high.
- Locked, feed 111 in place of 011, then continue 111,110,100 → a single err pulse, err_cnt=1, locked stays 1, no further errors.
- Locked, feed two wrong words (000-free, e.g. 110,110) → two err pulses, locked=0 after the second, err_cnt=2; clean sequence then relocks after seed+3 words.
- Locked, drop in_valid for 5 cycles with in_data toggling garbage, resume the correct sequence → no err, locked held.
- LOSS_CNT=8, ERR_W=2: inject 5 isolated errors in a locked stream → err_cnt stops at 3, locked stays 1. Then set mid-stream → all outputs 0 the next cycle, state HUNT.
- Macro defined, locked, valid 000 → zero_det and err pulse together, err_cnt+1. Macro undefined → zero_det stays 0, err still pulses.
